// File: rtl/lcd_text_pkg.sv
// Shared types and constants for the LCD text sequencer.
// Holds FSM/mode encodings, ASCII constants and the label table.
package lcd_text_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STROBE,
      S_GAP,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      M_IDLE,
      M_WORK,
      M_REST,
      M_DONE
   } mode_e;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   // Element 0 is the rightmost entry, so index by mode directly
   localparam logic [3:0][31:0] LABELS = {"DONE", "REST", "WORK", "IDLE"};

   typedef struct packed {
      mode_e      mode;
      logic [7:0] mins;
      logic [7:0] secs;
      logic [3:0] setn;
   } snap_t;

   function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
      return (n > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {4'h0, n};
   endfunction

   function automatic logic [7:0] label_char(input mode_e m,
                                             input logic [1:0] pos);
      return LABELS[m][{~pos, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_line_mux.sv
// Selects the ASCII character for one position of the 16-char line.
// Purely combinational: index plus snapshot in, character out.
module lcd_line_mux
   import lcd_text_pkg::*;
(
   input  logic [3:0] idx_i,
   input  snap_t      snap_i,
   output logic [7:0] char_o
);

   always_comb begin
      char_o = ASCII_SPACE;
      case (idx_i)
         4'd0, 4'd1, 4'd2, 4'd3:
            char_o = label_char(snap_i.mode, idx_i[1:0]);
         4'd5:  char_o = bcd_ascii(snap_i.mins[7:4]);
         4'd6:  char_o = bcd_ascii(snap_i.mins[3:0]);
         4'd7:  char_o = ASCII_COLON;
         4'd8:  char_o = bcd_ascii(snap_i.secs[7:4]);
         4'd9:  char_o = bcd_ascii(snap_i.secs[3:0]);
         4'd11: char_o = 8'h53;
         4'd12: char_o = 8'h45;
         4'd13: char_o = 8'h54;
         4'd15: char_o = bcd_ascii(snap_i.setn);
         default: char_o = ASCII_SPACE;
      endcase
   end

endmodule

// File: rtl/lcd_text_sequencer.sv
// Snapshots timer state and streams one formatted text line to the
// slow LCD driver, pacing each character with long hold/gap windows.
module lcd_text_sequencer
   import lcd_text_pkg::*;
#(
   parameter int unsigned HOLD_CYC = 65536,
   parameter int unsigned GAP_CYC  = 196608,
   parameter int unsigned LINE_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refresh,
   input  logic [1:0] mode,
   input  logic [7:0] min_bcd,
   input  logic [7:0] sec_bcd,
   input  logic [3:0] set_bcd,
   output logic [7:0] char_out,
   output logic       write_en,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int unsigned IW   = $clog2(LINE_LEN);

   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(LINE_LEN - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   snap_t         snap_q, snap_d;
   logic [7:0]    char_q, char_d;
   logic [7:0]    ch;
   logic          tick;
   logic          step_idx;

   assign tick     = (cnt_q == '0);
   assign step_idx = (state_q == S_GAP) && tick && (idx_q != LAST_IDX);

   // The mux sees next-cycle index/snapshot so char_out lands on STROBE entry
   always_comb begin
      snap_d = snap_q;
      idx_d  = idx_q;
      if (state_q == S_LOAD) begin
         snap_d = {mode, min_bcd, sec_bcd, set_bcd};
         idx_d  = '0;
      end else if (step_idx) begin
         idx_d = idx_q + 1'b1;
      end
   end

   lcd_line_mux u_mux (
      .idx_i  (idx_d),
      .snap_i (snap_d),
      .char_o (ch)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      char_d  = char_q;
      if (refresh && state_q != S_IDLE) pend_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (refresh || pend_q) state_d = S_LOAD;
         end
         S_LOAD: begin
            cnt_d   = HOLD_LD;
            char_d  = ch;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (tick) begin
               cnt_d   = GAP_LD;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (!tick) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = HOLD_LD;
               char_d  = ch;
               state_d = S_STROBE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         snap_q  <= '0;
         char_q  <= ASCII_SPACE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         snap_q  <= snap_d;
         char_q  <= char_d;
      end
   end

   assign char_out   = char_q;
   assign write_en   = (state_q == S_STROBE);
   assign busy       = (state_q == S_LOAD) || (state_q == S_STROBE) ||
                       (state_q == S_GAP);
   assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed and randomized frames checked against a string-level model
// of the text line and the hold/gap pacing.
module tb_lcd_text_sequencer;

   localparam int H = 4;
   localparam int G = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       refresh;
   logic [1:0] mode;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic [3:0] set_bcd;
   logic [7:0] char_out;
   logic       write_en;
   logic       busy;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   lcd_text_sequencer #(
      .HOLD_CYC (H),
      .GAP_CYC  (G),
      .LINE_LEN (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .refresh    (refresh),
      .mode       (mode),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
      .set_bcd    (set_bcd),
      .char_out   (char_out),
      .write_en   (write_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dig(input logic [3:0] n);
      if (n <= 4'd9) return 8'(48 + int'(n));
      return 8'h3F;
   endfunction

   function automatic string model(input logic [1:0] m, input logic [7:0] mi,
                                   input logic [7:0] se, input logic [3:0] st);
      string lab;
      case (m)
         2'd0: lab = "IDLE";
         2'd1: lab = "WORK";
         2'd2: lab = "REST";
         default: lab = "DONE";
      endcase
      return $sformatf("%s %c%c:%c%c SET %c", lab, dig(mi[7:4]), dig(mi[3:0]),
                       dig(se[7:4]), dig(se[3:0]), dig(st));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_str(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
      end
   endtask

   task automatic start();
      refresh = 1'b1;
      step();
      refresh = 1'b0;
   endtask

   // Entered in the LOAD cycle; returns in the DONE cycle
   task automatic frame(input string e, input int act, output string cap);
      logic ok;
      cap = "";
      chk("load_busy", 32'(busy), 1);
      for (int k = 0; k < 16; k++) begin
         ok = 1'b1;
         step();
         chk($sformatf("char%0d", k), 32'(char_out), 32'(e[k]));
         cap = {cap, $sformatf("%c", char_out)};
         if (act == 1 && k == 3) sec_bcd = 8'h40;
         if (act == 2 && (k == 2 || k == 5 || k == 9)) refresh = 1'b1;
         for (int i = 0; i < H; i++) begin
            if (i > 0) step();
            if (i == 1) refresh = 1'b0;
            if (write_en !== 1'b1 || char_out !== e[k] || busy !== 1'b1)
               ok = 1'b0;
         end
         for (int i = 0; i < G; i++) begin
            step();
            if (write_en !== 1'b0 || char_out !== e[k] || busy !== 1'b1 ||
                frame_done !== 1'b0)
               ok = 1'b0;
         end
         chk($sformatf("slot_timing%0d", k), 32'(ok), 1);
      end
      step();
      chk("done_pulse", 32'(frame_done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_we", 32'(write_en), 0);
      if (act == 2) refresh = 1'b1;
   endtask

   task automatic quiet(input int n, input string tag);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         if (write_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
            ok = 1'b0;
      end
      chk(tag, 32'(ok), 1);
   endtask

   task automatic after_done(input bit pend);
      step();
      refresh = 1'b0;
      chk("idle_fd", 32'(frame_done), 0);
      chk("idle_busy", 32'(busy), 0);
      if (pend) step();
      else quiet(20, "quiet_after");
   endtask

   initial begin
      string cap;
      string e;
      rst_n   = 1'b0;
      refresh = 1'b0;
      mode    = 2'd0;
      min_bcd = 8'h00;
      sec_bcd = 8'h00;
      set_bcd = 4'h0;
      step();
      step();
      chk("rst_char", 32'(char_out), 32'h20);
      chk("rst_we", 32'(write_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fd", 32'(frame_done), 0);
      rst_n = 1'b1;
      quiet(5, "quiet_reset");

      mode = 2'd1; min_bcd = 8'h05; sec_bcd = 8'h39; set_bcd = 4'h3;
      start();
      frame(model(mode, min_bcd, sec_bcd, set_bcd), 0, cap);
      chk_str("work_line", cap, "WORK 05:39 SET 3");
      after_done(1'b0);

      start();
      frame(model(2'd1, 8'h05, 8'h39, 4'h3), 1, cap);
      chk_str("snapshot_old", cap.substr(8, 9), "39");
      after_done(1'b0);
      start();
      frame(model(mode, min_bcd, sec_bcd, set_bcd), 0, cap);
      chk_str("snapshot_new", cap.substr(8, 9), "40");
      after_done(1'b0);

      start();
      frame(model(mode, min_bcd, sec_bcd, set_bcd), 2, cap);
      after_done(1'b1);
      frame(model(mode, min_bcd, sec_bcd, set_bcd), 0, cap);
      after_done(1'b0);

      mode = 2'd3; min_bcd = 8'hA2; sec_bcd = 8'h17; set_bcd = 4'h9;
      start();
      frame(model(mode, min_bcd, sec_bcd, set_bcd), 0, cap);
      chk_str("bad_digit", cap.substr(5, 6), "?2");
      chk_str("done_label", cap.substr(0, 3), "DONE");
      after_done(1'b0);

      repeat (4) begin
         mode    = 2'($urandom_range(0, 3));
         min_bcd = 8'($urandom);
         sec_bcd = 8'($urandom);
         set_bcd = 4'($urandom);
         start();
         frame(model(mode, min_bcd, sec_bcd, set_bcd), 0, cap);
         after_done(1'b0);
      end

      mode = 2'd2; min_bcd = 8'h12; sec_bcd = 8'h34; set_bcd = 4'h5;
      e = model(mode, min_bcd, sec_bcd, set_bcd);
      start();
      repeat (1 + 7 * (H + G) + 1) step();
      chk("pre_rst_we", 32'(write_en), 1);
      chk("pre_rst_char", 32'(char_out), 32'(e[7]));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_we", 32'(write_en), 0);
      chk("async_char", 32'(char_out), 32'h20);
      chk("async_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet(50, "no_resume");
      start();
      frame(e, 0, cap);
      after_done(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_text_sequencer.md
Name: lcd_text_sequencer

Overview:
Upstream feeder for the LCD driver in the fitness timer. It snapshots the timer state (mode, minutes, seconds, set number) and formats one 16-character text line. It then streams that line one ASCII character at a time on char_out/write_en. Strobes are paced so the slow, handshake-less LCD driver, which runs on a clk/65536 tick, sees every character for at least one full tick.

Parameters:
HOLD_CYC, 65536, clk cycles write_en is held high per character (at least one driver tick)
GAP_CYC, 196608, clk cycles write_en is low after each strobe; char_out stays stable (covers driver WRITE+HOLD)
LINE_LEN, 16, characters per frame; fixed layout below assumes 16

Ports:
clk  in  1  40 MHz system clock
rst_n  in  1  asynchronous, active-low reset
refresh  in  1  single-cycle request to send a new frame
mode  in  2  0=IDLE, 1=WORK, 2=REST, 3=DONE
min_bcd  in  8  minutes, [7:4] tens, [3:0] ones
sec_bcd  in  8  seconds, [7:4] tens, [3:0] ones
set_bcd  in  4  current set number, one BCD digit
char_out  out  8  ASCII character to the LCD driver data_in
write_en  out  1  character strobe to the LCD driver
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, char_out=8'h20, write_en=0, busy=0, frame_done=0.
  - Index, counters, pending flag and snapshot registers all cleared.
- Reset mid-frame: the frame is abandoned and no resume occurs; a new refresh is required.
- FSM states: IDLE, LOAD, STROBE, GAP, DONE.
- IDLE:
  - busy=0.
  - refresh=1 or pending=1 -> LOAD; pending is cleared.
- LOAD (1 cycle):
  - Registers mode, min_bcd, sec_bcd and set_bcd into the snapshot.
  - Sets idx=0 and busy=1. Next state is STROBE.
- STROBE:
  - write_en=1; char_out=char(idx) from the snapshot.
  - Stays HOLD_CYC cycles, then -> GAP.
- GAP:
  - write_en=0; char_out unchanged.
  - Stays GAP_CYC cycles.
  - Then, if idx==LINE_LEN-1 -> DONE; else idx+1 -> STROBE.
- DONE (1 cycle): frame_done=1, busy=0, write_en=0, then -> IDLE.
- Timing:
  - With LOAD at cycle t, slot k STROBE starts at t+1+k*(HOLD_CYC+GAP_CYC).
  - DONE falls at t+1+16*(HOLD_CYC+GAP_CYC).
  - char_out changes only on entry to STROBE.
- Line layout, idx 0..15:
  - 0-3: label "IDLE"/"WORK"/"REST"/"DONE" by snapshot mode.
  - 4: ' '.
  - 5, 6: minute tens, minute ones.
  - 7: ':'.
  - 8, 9: second tens, second ones.
  - 10: ' '.
  - 11-13: "SET".
  - 14: ' '.
  - 15: set digit.
- Digit encoding: a BCD nibble 0-9 maps to 8'h30+nibble; a nibble >9 maps to '?' (8'h3F). No arithmetic carries beyond 8 bits.
- refresh while busy: sets pending; multiple requests collapse to one. DONE is always followed by IDLE for one cycle, then LOAD.
- refresh in the same cycle as DONE: sets pending.
- Input changes mid-frame: no effect on the current frame (snapshot only).
- Counters: wide enough for max(HOLD_CYC, GAP_CYC); count down from value-1 to 0; wrap-free.

Decomposition:
- Package lcd_text_pkg:
  - FSM state encodings.
  - Mode encodings.
  - ASCII constants (SPACE, COLON, QMARK, ZERO).
  - 4x4 label character table.
- Sub-module lcd_line_mux: combinational; idx plus snapshot in, ASCII out; includes BCD->ASCII.
- Sequencing and pacing remain in the top module.

Test Plan:
- HOLD_CYC=4, GAP_CYC=8; mode=1, min=8'h05, sec=8'h39, set=4'h3; pulse refresh -> 16 strobes of 4 cycles each with 8-cycle gaps; captured string "WORK 05:39 SET 3"; frame_done 1+16*12=193 cycles after LOAD.
- Change sec_bcd to 8'h40 during slot 3 -> captured string still shows "39"; next frame shows "40".
- Three refresh pulses during a frame, plus one coincident with DONE -> exactly one extra frame, starting 2 cycles after frame_done.
- min_bcd=8'hA2, mode=3 -> characters 5-6 are "?2"; label "DONE".
- Deassert rst_n during STROBE of idx 7 -> write_en=0, char_out=8'h20, busy=0 immediately (async); after release, no activity until refresh.
- Check with the real LCD driver model and default parameters: every character produces exactly one driver WRITE/HOLD pair with the correct nibbles, and no character is skipped.
